// File: rtl/sd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sd_pkg : states, command bytes, error codes and register offsets |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_R1    = 3'd2,
      ST_TOKEN = 3'd3,
      ST_DATA  = 3'd4,
      ST_CRC   = 3'd5,
      ST_FIN   = 3'd6
   } state_t;

   localparam logic [7:0] CMD17       = 8'h51;
   localparam logic [7:0] TOKEN_START = 8'hFE;
   localparam logic [7:0] BYTE_IDLE   = 8'hFF;
   localparam logic [7:0] R1_READY    = 8'h00;

   localparam logic [2:0] ERR_NONE          = 3'd0;
   localparam logic [2:0] ERR_R1_TIMEOUT    = 3'd1;
   localparam logic [2:0] ERR_R1_BAD        = 3'd2;
   localparam logic [2:0] ERR_TOKEN_TIMEOUT = 3'd3;
   localparam logic [2:0] ERR_TOKEN_BAD     = 3'd4;
   localparam logic [2:0] ERR_CRC           = 3'd5;

   localparam logic [3:0] REG_CTRL = 4'd12;
   localparam logic [3:0] REG_LBA  = 4'd13;
   localparam logic [3:0] REG_DATA = 4'd14;
   localparam logic [3:0] REG_CODE = 4'd15;

   // CRC-16/CCITT, poly 0x1021, MSB first, one whole byte per call
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  byte_in);
      logic [15:0] c;
      c = crc_in ^ {byte_in, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc16.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sd_crc16 : byte-serial CRC-16/CCITT, one byte per cycle          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sd_crc16
   import sd_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = 16'h0000;
      end else if (en_i) begin
         crc_d = crc16_byte(crc_q, data_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         crc_q <= 16'h0000;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/sd_sector_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sd_sector_reader : CMD17 single-sector read into a 512x8 buffer  |
// | Option SD_SECTOR_CRC_EN checks the data CRC-16.  Rev 1.0         |
// +------------------------------------------------------------------+
module sd_sector_reader
   import sd_pkg::*;
#(
   parameter int BYTE_ADDR   = 0,
   parameter int R1_TRIES    = 8,
   parameter int TOKEN_TRIES = 4096
) (
   input  logic       cpuclk,
   input  logic       nrst,
   inout  wire  [7:0] data,
   input  logic       ncs,
   input  logic       nwr,
   input  logic       nrd,
   input  logic [3:0] addr,
   output logic       spi_own,
   output logic       xfer_start,
   output logic [7:0] xfer_tx,
   input  logic       xfer_busy,
   input  logic [7:0] xfer_rx
);

   state_t      state_q, state_d;
   logic [31:0] lba_q, lba_d;
   logic [8:0]  ptr_q, ptr_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  code_q, code_d;
   logic [7:0]  tx_q, tx_d;
   logic        done_q, done_d, err_q, err_d, own_q, own_d;
   logic        start_q, start_d, pend_q, pend_d, seen_q, seen_d;
   logic        got_wr_q, got_rd_q;
   logic [7:0]  rd_hold_q;
   logic [7:0]  mem_q [0:511];

   logic        sel, wr_act, rd_act, busy, xfer_done, fail;
   logic [2:0]  fail_code;
   logic [7:0]  rd_mux, tx_byte;
   logic [31:0] arg;
   logic        mem_we;

`ifdef SD_SECTOR_CRC_EN
   logic [15:0] crc_calc;
   logic [7:0]  crc_hi_q, crc_hi_d, crc_lo_q, crc_lo_d;
   logic        crc_clr, crc_en;

   sd_crc16 u_crc (
      .clk    (cpuclk),
      .nrst   (nrst),
      .clr_i  (crc_clr),
      .en_i   (crc_en),
      .data_i (xfer_rx),
      .crc_o  (crc_calc)
   );
`endif

   assign sel       = !ncs && (addr[3:2] == 2'b11);
   assign wr_act    = sel && !nwr && !got_wr_q;
   assign rd_act    = sel && !nrd && !got_rd_q;
   assign busy      = (state_q != ST_IDLE);
   assign xfer_done = pend_q && seen_q && !xfer_busy;
   assign arg       = (BYTE_ADDR != 0) ? (lba_q << 9) : lba_q;

   // Bus shows the live mux on the strobe's first cycle, then the value latched there
   assign data = (sel && !nrd) ? (got_rd_q ? rd_hold_q : rd_mux) : 8'hzz;

   always_comb begin
      case (addr)
         REG_CTRL: rd_mux = {5'b0, err_q, done_q, busy};
         REG_DATA: rd_mux = busy ? 8'hFF : mem_q[ptr_q];
         REG_CODE: rd_mux = {5'b0, code_q};
         default:  rd_mux = 8'hFF;
      endcase
   end

   always_comb begin
      tx_byte = BYTE_IDLE;
      if (state_q == ST_CMD) begin
         case (cnt_q[2:0])
            3'd0:    tx_byte = CMD17;
            3'd1:    tx_byte = arg[31:24];
            3'd2:    tx_byte = arg[23:16];
            3'd3:    tx_byte = arg[15:8];
            3'd4:    tx_byte = arg[7:0];
            default: tx_byte = BYTE_IDLE;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      lba_d     = lba_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      code_d    = code_q;
      tx_d      = tx_q;
      done_d    = done_q;
      err_d     = err_q;
      own_d     = own_q;
      start_d   = 1'b0;
      pend_d    = pend_q;
      seen_d    = seen_q;
      mem_we    = 1'b0;
      fail      = 1'b0;
      fail_code = ERR_NONE;
`ifdef SD_SECTOR_CRC_EN
      crc_hi_d  = crc_hi_q;
      crc_lo_d  = crc_lo_q;
      crc_clr   = 1'b0;
      crc_en    = 1'b0;
`endif

      if (wr_act && addr == REG_CTRL && data[1]) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end
      if (wr_act && addr == REG_LBA && !busy) begin
         lba_d = {lba_q[23:0], data};
      end
      if (rd_act && addr == REG_DATA && !busy) begin
         ptr_d = ptr_q + 9'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (wr_act && addr == REG_CTRL && data[0]) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               code_d  = ERR_NONE;
               ptr_d   = 9'd0;
               own_d   = 1'b1;
               cnt_d   = 16'd0;
               pend_d  = 1'b0;
               seen_d  = 1'b0;
               state_d = ST_CMD;
`ifdef SD_SECTOR_CRC_EN
               crc_clr = 1'b1;
`endif
            end
         end

         ST_FIN: begin
            done_d  = 1'b1;
            own_d   = 1'b0;
            ptr_d   = 9'd0;
            state_d = ST_IDLE;
`ifdef SD_SECTOR_CRC_EN
            if ({crc_hi_q, crc_lo_q} != crc_calc) begin
               err_d  = 1'b1;
               code_d = ERR_CRC;
            end
`endif
         end

         default: begin
            if (!pend_q) begin
               if (!xfer_busy) begin
                  start_d = 1'b1;
                  tx_d    = tx_byte;
                  pend_d  = 1'b1;
                  seen_d  = 1'b0;
               end
            end else begin
               if (xfer_busy) begin
                  seen_d = 1'b1;
               end
               if (xfer_done) begin
                  pend_d = 1'b0;
                  case (state_q)
                     ST_CMD: begin
                        if (cnt_q == 16'd5) begin
                           cnt_d   = 16'd0;
                           state_d = ST_R1;
                        end else begin
                           cnt_d = cnt_q + 16'd1;
                        end
                     end
                     ST_R1: begin
                        if (xfer_rx == R1_READY) begin
                           cnt_d   = 16'd0;
                           state_d = ST_TOKEN;
                        end else if (xfer_rx == BYTE_IDLE) begin
                           if (cnt_q == 16'(R1_TRIES - 1)) begin
                              fail      = 1'b1;
                              fail_code = ERR_R1_TIMEOUT;
                           end else begin
                              cnt_d = cnt_q + 16'd1;
                           end
                        end else begin
                           fail      = 1'b1;
                           fail_code = ERR_R1_BAD;
                        end
                     end
                     ST_TOKEN: begin
                        if (xfer_rx == TOKEN_START) begin
                           cnt_d   = 16'd0;
                           state_d = ST_DATA;
                        end else if (xfer_rx == BYTE_IDLE) begin
                           if (cnt_q == 16'(TOKEN_TRIES - 1)) begin
                              fail      = 1'b1;
                              fail_code = ERR_TOKEN_TIMEOUT;
                           end else begin
                              cnt_d = cnt_q + 16'd1;
                           end
                        end else begin
                           fail      = 1'b1;
                           fail_code = ERR_TOKEN_BAD;
                        end
                     end
                     ST_DATA: begin
                        mem_we = 1'b1;
`ifdef SD_SECTOR_CRC_EN
                        crc_en = 1'b1;
`endif
                        if (cnt_q == 16'd511) begin
                           cnt_d   = 16'd0;
                           state_d = ST_CRC;
                        end else begin
                           cnt_d = cnt_q + 16'd1;
                        end
                     end
                     ST_CRC: begin
                        if (cnt_q == 16'd0) begin
`ifdef SD_SECTOR_CRC_EN
                           crc_hi_d = xfer_rx;
`endif
                           cnt_d = 16'd1;
                        end else begin
`ifdef SD_SECTOR_CRC_EN
                           crc_lo_d = xfer_rx;
`endif
                           state_d = ST_FIN;
                        end
                     end
                     default: state_d = ST_IDLE;
                  endcase
               end
            end
         end
      endcase

      // Errors are only detected on a completed byte, so nothing is in flight here
      if (fail) begin
         err_d   = 1'b1;
         done_d  = 1'b1;
         own_d   = 1'b0;
         code_d  = fail_code;
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge cpuclk) begin
      if (!nrst) begin
         state_q   <= ST_IDLE;
         lba_q     <= 32'd0;
         ptr_q     <= 9'd0;
         cnt_q     <= 16'd0;
         code_q    <= ERR_NONE;
         tx_q      <= 8'hFF;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         own_q     <= 1'b0;
         start_q   <= 1'b0;
         pend_q    <= 1'b0;
         seen_q    <= 1'b0;
         got_wr_q  <= 1'b0;
         got_rd_q  <= 1'b0;
         rd_hold_q <= 8'hFF;
      end else begin
         state_q   <= state_d;
         lba_q     <= lba_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
         err_q     <= err_d;
         own_q     <= own_d;
         start_q   <= start_d;
         pend_q    <= pend_d;
         seen_q    <= seen_d;
         got_wr_q  <= sel && !nwr;
         got_rd_q  <= sel && !nrd;
         if (rd_act) begin
            rd_hold_q <= rd_mux;
         end
      end
   end

`ifdef SD_SECTOR_CRC_EN
   always_ff @(posedge cpuclk) begin
      if (!nrst) begin
         crc_hi_q <= 8'h00;
         crc_lo_q <= 8'h00;
      end else begin
         crc_hi_q <= crc_hi_d;
         crc_lo_q <= crc_lo_d;
      end
   end
`endif

   always_ff @(posedge cpuclk) begin
      if (nrst && mem_we) begin
         mem_q[cnt_q[8:0]] <= xfer_rx;
      end
   end

   assign spi_own    = own_q;
   assign xfer_start = start_q;
   assign xfer_tx    = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_reader.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_sd_sector_reader : directed bench with a shared byte-engine   |
// | and SD card model.  Rev 1.0                                      |
// +------------------------------------------------------------------+
module tb_sd_sector_reader;

   logic       cpuclk = 1'b0;
   logic       nrst   = 1'b0;
   logic       ncs0   = 1'b1;
   logic       ncs1   = 1'b1;
   logic       nwr    = 1'b1;
   logic       nrd    = 1'b1;
   logic [3:0] addr   = 4'd0;
   logic       cpu_drv  = 1'b0;
   logic [7:0] cpu_dout = 8'h00;
   wire  [7:0] data_w;

   assign data_w = cpu_drv ? cpu_dout : 8'hzz;

   always #125 cpuclk = ~cpuclk;

   logic       own0, own1, st0, st1;
   logic [7:0] tx0, tx1;
   logic       eng_busy = 1'b0;
   logic [7:0] eng_rx   = 8'hFF;

   wire        eng_own   = own0 | own1;
   wire        eng_start = own0 ? st0 : (own1 ? st1 : 1'b0);
   wire  [7:0] eng_tx    = own0 ? tx0 : tx1;

   sd_sector_reader #(.BYTE_ADDR(0), .R1_TRIES(8), .TOKEN_TRIES(4096)) u_dut0 (
      .cpuclk(cpuclk), .nrst(nrst), .data(data_w), .ncs(ncs0), .nwr(nwr), .nrd(nrd),
      .addr(addr), .spi_own(own0), .xfer_start(st0), .xfer_tx(tx0),
      .xfer_busy(eng_busy), .xfer_rx(eng_rx));

   sd_sector_reader #(.BYTE_ADDR(1), .R1_TRIES(8), .TOKEN_TRIES(4096)) u_dut1 (
      .cpuclk(cpuclk), .nrst(nrst), .data(data_w), .ncs(ncs1), .nwr(nwr), .nrd(nrd),
      .addr(addr), .spi_own(own1), .xfer_start(st1), .xfer_tx(tx1),
      .xfer_busy(eng_busy), .xfer_rx(eng_rx));

   // Card script: 0 normal, 1 R1 stuck, 2 bad token, 3 corrupted CRC
   int          mode    = 0;
   logic [15:0] crc_exp = 16'h0000;
   int          k       = 0;
   int          lat     = 0;
   logic        own_prev = 1'b0;
   logic [7:0]  rx_next  = 8'hFF;
   logic [7:0]  txlog [0:15];

   int tests = 0;
   int fails = 0;

   function automatic logic [7:0] resp(input int idx);
      logic [7:0] r;
      r = 8'hFF;
      if (idx >= 6) begin
         case (mode)
            1: r = 8'hFF;
            2: r = (idx == 6) ? 8'h00 : ((idx == 7) ? 8'h09 : 8'hFF);
            default: begin
               if (idx == 6) r = 8'h00;
               else if (idx == 7 || idx == 8) r = 8'hFF;
               else if (idx == 9) r = 8'hFE;
               else if (idx >= 10 && idx <= 521) r = 8'(idx - 10);
               else if (idx == 522) r = (mode == 3) ? ~crc_exp[15:8] : crc_exp[15:8];
               else if (idx == 523) r = (mode == 3) ? ~crc_exp[7:0] : crc_exp[7:0];
            end
         endcase
      end
      return r;
   endfunction

   always @(posedge cpuclk) begin
      own_prev <= eng_own;
      if (eng_own && !own_prev) begin
         k <= 0;
      end else if (eng_start) begin
         if (k < 16) txlog[k[3:0]] <= eng_tx;
         rx_next  <= resp(k);
         k        <= k + 1;
         eng_busy <= 1'b1;
         lat      <= 3;
      end
      if (eng_busy && !eng_start) begin
         if (lat == 0) begin
            eng_busy <= 1'b0;
            eng_rx   <= rx_next;
         end else begin
            lat <= lat - 1;
         end
      end
   end

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      tests++;
      assert (obs == exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cpu_wr(input logic which, input logic [3:0] a, input logic [7:0] d);
      @(negedge cpuclk);
      addr = a; cpu_dout = d; cpu_drv = 1'b1; nwr = 1'b0;
      if (which) ncs1 = 1'b0; else ncs0 = 1'b0;
      @(negedge cpuclk);
      @(negedge cpuclk);
      nwr = 1'b1; ncs0 = 1'b1; ncs1 = 1'b1; cpu_drv = 1'b0;
   endtask

   task automatic cpu_rd(input logic which, input logic [3:0] a, output logic [7:0] d);
      @(negedge cpuclk);
      addr = a; nrd = 1'b0;
      if (which) ncs1 = 1'b0; else ncs0 = 1'b0;
      @(negedge cpuclk);
      @(negedge cpuclk);
      d = data_w;
      nrd = 1'b1; ncs0 = 1'b1; ncs1 = 1'b1;
   endtask

   task automatic wait_idle(input logic which, input string tag);
      logic [7:0] s;
      int n;
      s = 8'h01;
      for (n = 0; n < 3000; n++) begin
         cpu_rd(which, 4'd12, s);
         if (s[0] == 1'b0) break;
      end
      tests++;
      assert (n < 3000) else begin
         fails++;
         $error("FAIL %s: observed still busy after %0d polls expected idle", tag, n);
      end
   endtask

   task automatic wait_k(input int target, input string tag);
      int n;
      for (n = 0; n < 8000 && k < target; n++) @(posedge cpuclk);
      tests++;
      assert (k >= target) else begin
         fails++;
         $error("FAIL %s: observed byte count %0d expected >= %0d", tag, k, target);
      end
   endtask

   initial begin
      #(60000 * 250);
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   logic [7:0] rd;
   logic [7:0] exp_cmd [0:5];

   initial begin
      // Reference CRC-16/CCITT over bytes i&0xFF, computed bit by bit
      crc_exp = 16'h0000;
      for (int i = 0; i < 512; i++) begin
         logic [7:0] b;
         b = 8'(i);
         for (int j = 7; j >= 0; j--) begin
            logic fb;
            fb = crc_exp[15] ^ b[j];
            crc_exp = {crc_exp[14:0], 1'b0};
            if (fb) crc_exp = crc_exp ^ 16'h1021;
         end
      end

      // Reset
      nrst = 1'b0;
      repeat (3) @(posedge cpuclk);
      @(negedge cpuclk);
      nrst = 1'b1;
      @(negedge cpuclk);
      check8("reset_own0", {7'd0, own0}, 8'h00);
      check8("reset_own1", {7'd0, own1}, 8'h00);
      check8("reset_start", {7'd0, st0}, 8'h00);
      check8("reset_tx", tx0, 8'hFF);
      cpu_rd(1'b0, 4'd12, rd); check8("reset_status", rd, 8'h00);
      cpu_rd(1'b0, 4'd15, rd); check8("reset_code", rd, 8'h00);

      // Normal sector read, LBA 0x00001234, block addressing
      cpu_wr(1'b0, 4'd13, 8'h00);
      cpu_wr(1'b0, 4'd13, 8'h00);
      cpu_wr(1'b0, 4'd13, 8'h12);
      cpu_wr(1'b0, 4'd13, 8'h34);
      mode = 0;
      cpu_wr(1'b0, 4'd12, 8'h01);
      check8("normal_own_busy", {7'd0, own0}, 8'h01);
      wait_idle(1'b0, "normal_wait");
      exp_cmd[0] = 8'h51; exp_cmd[1] = 8'h00; exp_cmd[2] = 8'h00;
      exp_cmd[3] = 8'h12; exp_cmd[4] = 8'h34; exp_cmd[5] = 8'hFF;
      for (int i = 0; i < 6; i++) check8($sformatf("normal_cmd%0d", i), txlog[i], exp_cmd[i]);
      check_int("normal_xfers", k, 524);
      check8("normal_own_done", {7'd0, own0}, 8'h00);
      cpu_rd(1'b0, 4'd12, rd); check8("normal_status", rd, 8'h02);
      cpu_rd(1'b0, 4'd15, rd); check8("normal_code", rd, 8'h00);
      for (int i = 0; i < 512; i++) begin
         cpu_rd(1'b0, 4'd14, rd);
         check8($sformatf("normal_buf%0d", i), rd, 8'(i));
      end
      cpu_rd(1'b0, 4'd14, rd); check8("ptr_wrap", rd, 8'h00);

      // Corrupted CRC; an LBA write while busy must be ignored
      mode = 3;
      cpu_wr(1'b0, 4'd12, 8'h01);
      cpu_wr(1'b0, 4'd13, 8'h77);
      wait_idle(1'b0, "badcrc_wait");
`ifdef SD_SECTOR_CRC_EN
      cpu_rd(1'b0, 4'd12, rd); check8("badcrc_status", rd, 8'h06);
      cpu_rd(1'b0, 4'd15, rd); check8("badcrc_code", rd, 8'h05);
`else
      cpu_rd(1'b0, 4'd12, rd); check8("badcrc_status", rd, 8'h02);
      cpu_rd(1'b0, 4'd15, rd); check8("badcrc_code", rd, 8'h00);
`endif
      cpu_rd(1'b0, 4'd14, rd); check8("badcrc_buf0", rd, 8'h00);

      // R1 stuck at 0xFF: eight polls then timeout
      cpu_wr(1'b0, 4'd12, 8'h02);
      cpu_rd(1'b0, 4'd12, rd); check8("clear_status", rd, 8'h00);
      mode = 1;
      cpu_wr(1'b0, 4'd12, 8'h03);
      wait_idle(1'b0, "r1_wait");
      check_int("r1_xfers", k, 14);
      for (int i = 1; i < 5; i++) check8($sformatf("r1_lba_kept%0d", i), txlog[i], exp_cmd[i]);
      for (int i = 6; i < 14; i++) check8($sformatf("r1_poll%0d", i), txlog[i], 8'hFF);
      cpu_rd(1'b0, 4'd12, rd); check8("r1_status", rd, 8'h06);
      cpu_rd(1'b0, 4'd15, rd); check8("r1_code", rd, 8'h01);
      check8("r1_own", {7'd0, own0}, 8'h00);

      // Bad data token: no buffer writes, old contents stay
      mode = 2;
      cpu_wr(1'b0, 4'd12, 8'h01);
      wait_idle(1'b0, "tok_wait");
      check_int("tok_xfers", k, 8);
      cpu_rd(1'b0, 4'd12, rd); check8("tok_status", rd, 8'h06);
      cpu_rd(1'b0, 4'd15, rd); check8("tok_code", rd, 8'h04);
      for (int i = 0; i < 3; i++) begin
         cpu_rd(1'b0, 4'd14, rd);
         check8($sformatf("tok_buf%0d", i), rd, 8'(i));
      end

      // Byte addressing instance, LBA 1 -> argument 0x00000200
      cpu_wr(1'b1, 4'd13, 8'h00);
      cpu_wr(1'b1, 4'd13, 8'h00);
      cpu_wr(1'b1, 4'd13, 8'h00);
      cpu_wr(1'b1, 4'd13, 8'h01);
      mode = 1;
      cpu_wr(1'b1, 4'd12, 8'h01);
      wait_idle(1'b1, "sdsc_wait");
      exp_cmd[0] = 8'h51; exp_cmd[1] = 8'h00; exp_cmd[2] = 8'h00;
      exp_cmd[3] = 8'h02; exp_cmd[4] = 8'h00; exp_cmd[5] = 8'hFF;
      for (int i = 0; i < 6; i++) check8($sformatf("sdsc_cmd%0d", i), txlog[i], exp_cmd[i]);
      cpu_rd(1'b1, 4'd12, rd); check8("sdsc_status", rd, 8'h06);
      cpu_rd(1'b1, 4'd15, rd); check8("sdsc_code", rd, 8'h01);

      // Restart and reads while busy, then reset mid-transfer
      mode = 0;
      cpu_wr(1'b0, 4'd12, 8'h01);
      wait_k(110, "busy_reach100");
      cpu_wr(1'b0, 4'd12, 8'h01);
      cpu_rd(1'b0, 4'd14, rd); check8("busy_read0", rd, 8'hFF);
      cpu_rd(1'b0, 4'd14, rd); check8("busy_read1", rd, 8'hFF);
      cpu_rd(1'b0, 4'd12, rd); check8("busy_status", rd, 8'h01);
      check8("busy_own", {7'd0, own0}, 8'h01);
      wait_k(210, "busy_reach200");
      @(negedge cpuclk);
      nrst = 1'b0;
      @(posedge cpuclk);
      #1;
      check8("rst_own", {7'd0, own0}, 8'h00);
      check8("rst_start", {7'd0, st0}, 8'h00);
      check8("rst_tx", tx0, 8'hFF);
      @(negedge cpuclk);
      nrst = 1'b1;
      cpu_rd(1'b0, 4'd12, rd); check8("rst_status", rd, 8'h00);
      cpu_rd(1'b0, 4'd14, rd); check8("rst_buf0", rd, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
